// File: rtl/powlib_edgefilt.sv
// Purpose : W-channel glitch filter; a channel accepts a new level after D consecutive
//           differing qualified samples and may raise a one-cycle edge pulse and sticky flag.
// Latency : state/edge_pulse/sticky update on the D-th differing valid sampling edge; cnt one clock later.
// Backpressure: none; events are reported once and never held or queued.
//
// Optional feature: define POWLIB_EDGEFILT_CNT_EN to compile in the saturating event
// counter together with its cntclr input and cnt output (parameter CW).
//
// Ports:
//   clk        clock, all flops on the rising edge
//   rst        asynchronous active-low reset (release synchronised by the driver)
//   in         raw channel levels (already synchronised)
//   vld        sample qualifier; in is only considered when high
//   posen      per-channel rising-edge event enable (sampled at the toggling edge)
//   negen      per-channel falling-edge event enable (sampled at the toggling edge)
//   clr        per-channel sticky clear (a same-cycle set wins)
//   state      filtered level, registered
//   edge_pulse one-cycle event pulse, registered, coincides with the state change
//   vldout     registered OR of edge_pulse
//   sticky     latched events
//   cntclr     counter clear, wins over increment       (counter build only)
//   cnt        saturating count of edge_pulse bits       (counter build only)
module powlib_edgefilt #(
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = '0,
    parameter int           D    = 4
`ifdef POWLIB_EDGEFILT_CNT_EN
    ,
    parameter int           CW   = 8
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in,
    input  logic         vld,
    input  logic [W-1:0] posen,
    input  logic [W-1:0] negen,
    input  logic [W-1:0] clr,
    output logic [W-1:0] state,
    output logic [W-1:0] edge_pulse,
    output logic         vldout,
    output logic [W-1:0] sticky
`ifdef POWLIB_EDGEFILT_CNT_EN
    ,
    input  logic          cntclr,
    output logic [CW-1:0] cnt
`endif
);

    // Stability counter counts differing samples already seen; the D-th one toggles,
    // so the counter only ever needs to reach D-1.
    localparam int             SCW     = $clog2(D + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(D - 1);

    logic [SCW-1:0] sc_q [W];
    logic [SCW-1:0] sc_d [W];
    logic [W-1:0]   state_q,  state_d;
    logic [W-1:0]   edge_q,   edge_d;
    logic           vldout_q, vldout_d;
    logic [W-1:0]   sticky_q, sticky_d;

    always_comb begin
        state_d = state_q;
        edge_d  = '0;
        for (int i = 0; i < W; i++) begin
            sc_d[i] = sc_q[i];
            // Gaps (vld low) hold both counter and level so a run survives them.
            if (vld) begin
                if (in[i] != state_q[i]) begin
                    if (sc_q[i] == SC_LAST) begin
                        state_d[i] = ~state_q[i];
                        sc_d[i]    = '0;
                        // Current level 1 means this is a falling transition.
                        edge_d[i]  = state_q[i] ? negen[i] : posen[i];
                    end else begin
                        sc_d[i] = sc_q[i] + SCW'(1);
                    end
                end else begin
                    // Any agreeing sample restarts the run.
                    sc_d[i] = '0;
                end
            end
        end
        // Set has priority over a simultaneous clear.
        sticky_d = (sticky_q & ~clr) | edge_d;
        vldout_d = |edge_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < W; i++) begin
                sc_q[i] <= '0;
            end
            state_q  <= INIT;
            edge_q   <= '0;
            vldout_q <= 1'b0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                sc_q[i] <= sc_d[i];
            end
            state_q  <= state_d;
            edge_q   <= edge_d;
            vldout_q <= vldout_d;
            sticky_q <= sticky_d;
        end
    end

    assign state      = state_q;
    assign edge_pulse = edge_q;
    assign vldout     = vldout_q;
    assign sticky     = sticky_q;

`ifdef POWLIB_EDGEFILT_CNT_EN
    // Counter accumulates the registered pulses, so it trails edge_pulse by one clock.
    localparam int            PCW     = $clog2(W + 1);
    localparam int            SW      = ((CW > PCW) ? CW : PCW) + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PCW-1:0] pop;
    logic [SW-1:0]  sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + PCW'(edge_q[i]);
        end
        // One extra bit of headroom makes overflow visible for saturation.
        sum = SW'(cnt_q) + SW'(pop);
        if (cntclr) begin
            cnt_d = '0;
        end else if (sum > SW'(CNT_MAX)) begin
            cnt_d = CNT_MAX;
        end else begin
            cnt_d = sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_powlib_edgefilt.sv
module tb_powlib_edgefilt;

    localparam int           W    = 4;
    localparam logic [W-1:0] INIT = 4'h0;
    localparam int           D    = 3;
`ifdef POWLIB_EDGEFILT_CNT_EN
    localparam int           CW   = 2;
    localparam int           CMAX = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         vld;
    logic [W-1:0] posen;
    logic [W-1:0] negen;
    logic [W-1:0] clr;
    logic [W-1:0] state;
    logic [W-1:0] edge_pulse;
    logic         vldout;
    logic [W-1:0] sticky;
`ifdef POWLIB_EDGEFILT_CNT_EN
    logic          cntclr;
    logic [CW-1:0] cnt;
`endif

    powlib_edgefilt #(
        .W    (W),
        .INIT (INIT),
        .D    (D)
`ifdef POWLIB_EDGEFILT_CNT_EN
        ,
        .CW   (CW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .vld        (vld),
        .posen      (posen),
        .negen      (negen),
        .clr        (clr),
        .state      (state),
        .edge_pulse (edge_pulse),
        .vldout     (vldout),
        .sticky     (sticky)
`ifdef POWLIB_EDGEFILT_CNT_EN
        ,
        .cntclr     (cntclr),
        .cnt        (cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a level is accepted once the last D valid samples since the
    // previous acceptance (or reset) all disagree with the current level.
    logic [W-1:0] samp_q [$];
    int           since [W];
    logic [W-1:0] m_state;
    logic [W-1:0] m_edge;
    logic [W-1:0] m_sticky;
    logic         m_vldout;
    int           m_cnt;

    task automatic model_reset();
        for (int i = 0; i < W; i++) since[i] = samp_q.size();
        m_state  = INIT;
        m_edge   = '0;
        m_sticky = '0;
        m_vldout = 1'b0;
        m_cnt    = 0;
    endtask

    task automatic model_update();
        logic [W-1:0] new_edge;
        logic [W-1:0] s;
        int           n;
        bit           all_diff;
        if (!rst) begin
            model_reset();
            return;
        end
`ifdef POWLIB_EDGEFILT_CNT_EN
        if (cntclr) m_cnt = 0;
        else begin
            m_cnt = m_cnt + $countones(m_edge);
            if (m_cnt > CMAX) m_cnt = CMAX;
        end
`endif
        new_edge = '0;
        if (vld) begin
            samp_q.push_back(din);
            n = samp_q.size();
            for (int i = 0; i < W; i++) begin
                if (n - since[i] >= D) begin
                    all_diff = 1'b1;
                    for (int k = n - D; k < n; k++) begin
                        s = samp_q[k];
                        if (s[i] == m_state[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        new_edge[i] = m_state[i] ? negen[i] : posen[i];
                        m_state[i]  = ~m_state[i];
                        since[i]    = n;
                    end
                end
            end
        end
        m_edge   = new_edge;
        m_sticky = (m_sticky & ~clr) | new_edge;
        m_vldout = |new_edge;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"},  32'(state),      32'(m_state));
        chk({tag, ".edge"},   32'(edge_pulse), 32'(m_edge));
        chk({tag, ".vldout"}, 32'(vldout),     32'(m_vldout));
        chk({tag, ".sticky"}, 32'(sticky),     32'(m_sticky));
`ifdef POWLIB_EDGEFILT_CNT_EN
        chk({tag, ".cnt"},    32'(cnt),        32'(m_cnt));
`endif
    endtask

    // Advance n clocks; inputs are stable across each edge, outputs sampled 1 time unit later.
    task automatic step(input string tag, input int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            #1;
            check_model(tag);
        end
    endtask

    initial begin
        rst   = 1'b0;
        din   = 4'hF;
        vld   = 1'b0;
        posen = 4'hF;
        negen = 4'hF;
        clr   = 4'h0;
`ifdef POWLIB_EDGEFILT_CNT_EN
        cntclr = 1'b0;
`endif
        model_reset();
        #1;
        chk("reset.state",  32'(state),      32'h0);
        chk("reset.edge",   32'(edge_pulse), 32'h0);
        chk("reset.sticky", 32'(sticky),     32'h0);
        chk("reset.vldout", 32'(vldout),     32'h0);
        step("in_reset", 2);
        rst = 1'b1;
        step("idle_novld", 10);
        chk("idle.state", 32'(state), 32'h0);

        // Glitch rejection: two differing samples then an agreeing one.
        vld = 1'b1;
        din = 4'h1;
        step("glitch", 2);
        din = 4'h0;
        step("glitch", 1);
        chk("glitch.state", 32'(state),      32'h0);
        chk("glitch.edge",  32'(edge_pulse), 32'h0);
        din = 4'h1;
        step("rise0", 2);
        chk("rise0.early", 32'(state), 32'h0);
        step("rise0", 1);
        chk("rise0.state",  32'(state),      32'h1);
        chk("rise0.edge",   32'(edge_pulse), 32'h1);
        chk("rise0.vldout", 32'(vldout),     32'h1);
        step("rise0_after", 1);
        chk("rise0.pulse_end", 32'(edge_pulse), 32'h0);

        // Qualifier gaps do not break a run.
        din = 4'h3;
        vld = 1'b1; step("gap", 1);
        vld = 1'b0; step("gap", 1);
        vld = 1'b1; step("gap", 1);
        vld = 1'b0; step("gap", 1);
        chk("gap.early", 32'(state), 32'h1);
        vld = 1'b1; step("gap", 1);
        chk("gap.state", 32'(state),      32'h3);
        chk("gap.edge",  32'(edge_pulse), 32'h2);

        // Falling-only events on channel 2.
        posen = 4'h0;
        negen = 4'hF;
        din   = 4'h7;
        step("mode_rise", 3);
        chk("mode.rise_state", 32'(state),      32'h7);
        chk("mode.rise_edge",  32'(edge_pulse), 32'h0);
        din = 4'h3;
        step("mode_fall", 3);
        chk("mode.fall_state", 32'(state),      32'h3);
        chk("mode.fall_edge",  32'(edge_pulse), 32'h4);
        chk("mode.sticky2",    32'(sticky[2]),  32'h1);

        // Sticky: clear arriving with the setting edge loses; one cycle later it clears.
        posen = 4'hF;
        din   = 4'hB;
        step("sticky", 2);
        clr = 4'h8;
        step("sticky_set", 1);
        chk("sticky.set_wins", 32'(sticky[3]), 32'h1);
        step("sticky_clr", 1);
        chk("sticky.cleared", 32'(sticky[3]), 32'h0);
        clr = 4'h0;

`ifdef POWLIB_EDGEFILT_CNT_EN
        cntclr = 1'b1;
        step("cnt_clr", 1);
        cntclr = 1'b0;
        chk("cnt.cleared", 32'(cnt), 32'h0);
        din = 4'h8;
        step("cnt_two", 4);
        chk("cnt.two", 32'(cnt), 32'h2);
        din = 4'hB;
        step("cnt_sat", 4);
        chk("cnt.saturated", 32'(cnt), 32'h3);
        din = 4'h8;
        step("cnt_pre", 3);
        chk("cnt.edge_vis", 32'(edge_pulse), 32'h3);
        cntclr = 1'b1;
        step("cnt_clrwin", 1);
        chk("cnt.clr_wins", 32'(cnt), 32'h0);
        cntclr = 1'b0;
`endif

        // Randomised traffic with slowly-changing inputs so runs of D occur often.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(3) == 0) din[i] = ~din[i];
            end
            vld   = ($urandom_range(4) != 0);
            posen = W'($urandom);
            negen = W'($urandom);
            clr   = ($urandom_range(7) == 0) ? W'($urandom) : '0;
`ifdef POWLIB_EDGEFILT_CNT_EN
            cntclr = ($urandom_range(15) == 0);
`endif
            if (c == 1500) begin
                // Asynchronous reset mid-run, away from any clock edge.
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                check_model("async_reset");
                step("in_reset2", 2);
                rst = 1'b1;
            end
            step("random", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/powlib_edgefilt.md
# powlib_edgefilt

Multi-channel, glitch-filtered edge detector for the powlib library. Each of W channels is debounced: a new level is accepted only after D consecutive qualified samples. Each accepted transition can raise a one-cycle edge pulse and a sticky flag, with rising and falling detection enabled per channel at run time. It sits between asynchronous or noisy status inputs (already synchronised) and control logic that needs clean, qualified events.

## Interface
- W, 8, number of channels (≥1)
- INIT, 0, W-bit reset value of the filtered level `state`
- D, 4, consecutive differing valid samples required to accept a new level (≥1)
- CW, 8, event counter width; used only with `POWLIB_EDGEFILT_CNT_EN`

Ports:
- clk  in  1  clock; all flops on rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release by the driver
- in  in  W  raw channel levels
- vld  in  1  sample qualifier; `in` is considered only when 1
- posen  in  W  per-channel rising-edge enable
- negen  in  W  per-channel falling-edge enable
- clr  in  W  per-channel sticky clear
- state  out  W  filtered level, registered
- edge  out  W  one-cycle event pulse, registered
- vldout  out  1  registered OR of `edge`
- sticky  out  W  latched events
- cntclr  in  1  counter clear (macro only)
- cnt  out  CW  saturating event count (macro only)

## Operation
Each channel has a stability counter `sc`, width clog2(D+1).

Filter, evaluated on each clock with `vld`=1:
- If `in[i]`≠`state[i]` and `sc`<D-1: `sc` increments.
- If `in[i]`≠`state[i]` and `sc`=D-1: `state[i]` toggles and `sc` clears to 0.
- If `in[i]`=`state[i]`: `sc` clears to 0. A single agreeing sample restarts the count.
- With `vld`=0: `sc` and `state` hold. Gaps do not break a run.
- With D=1, `state` follows `in` on every valid cycle.

Edge:
- `edge[i]` is 1 for exactly the cycle after a toggle when either:
  - the toggle is 0→1 and `posen[i]`=1, or
  - the toggle is 1→0 and `negen[i]`=1.
- `posen` and `negen` are sampled at the toggling clock edge.
- A toggle with its enable low still updates `state` but produces no pulse.

Sticky:
- `sticky[i]` is set by the same condition that sets `edge[i]`, in the same cycle.
- `clr[i]` clears it.
- Set and clear in the same cycle: set wins.

Counter:
- `cnt` increments by the number of `edge` bits asserted each cycle.
- Saturates at 2^CW-1 and never wraps.
- `cntclr` forces 0 and wins over an increment in the same cycle.

## Timing
- Reset values: `state`=INIT, `edge`=0, `vldout`=0, `sticky`=0, all `sc`=0, `cnt`=0.
- Reset is asynchronous: asserting `rst` mid-run discards partial runs and pending events immediately.
- Latency from the first differing sample to the `state` change:
  - D clock edges if `vld` is continuously high; the `state` flip, `edge` and `sticky` appear at the D-th sampling edge.
  - Otherwise, D valid sampling edges.
- `edge` and `state` change on the same clock edge.
- `vldout` is registered and coincides with `edge`.
- `cnt` reflects a cycle's edges one clock after `edge` is visible.
- Channels are fully independent: simultaneous toggles on all channels are all reported in the same cycle.
- There is no handshake back-pressure. Events are never held or queued.

## Configuration
`POWLIB_EDGEFILT_CNT_EN`:
- Defined: the event counter is compiled in, together with the `cntclr` input and `cnt` output.
- Undefined: both ports are absent and no counter logic is generated. All other behaviour is identical.

## Test plan
- Reset: drive `rst`=0 with `in`=4'hF, W=4, INIT=4'h0, D=3 -> `state`=0, `edge`=0, `sticky`=0. After release with `vld`=0 for 10 cycles -> `state` stays 0.
- Glitch rejection: `vld`=1, `in[0]`=1 for 2 cycles then 0 -> no `state`/`edge` change. Then `in[0]`=1 for 3 cycles -> `state[0]`=1 at the third edge, `edge[0]`=1 and `vldout`=1 for one cycle.
- Qualifier gaps: `in[1]`=1 with `vld` sequence 1,0,1,0,1 -> `state[1]` flips on the fifth edge and not earlier.
- Mode: `posen`=0, `negen`=4'hF; rise on ch2 then fall after 3 cycles each -> `state[2]` follows both, `edge[2]` pulses only on the fall, `sticky[2]`=1.
- Sticky collision: `clr[3]`=1 in the exact cycle `edge[3]` asserts -> `sticky[3]`=1. `clr[3]`=1 one cycle later -> `sticky[3]`=0.
- Counter (macro defined, CW=2): two cycles with 2 edges each -> `cnt`=3 (saturated, no wrap). `cntclr`=1 in a cycle with an edge -> `cnt`=0 next cycle.
